// File: rtl/patgen_pkg.sv
// Shared types and constants for the pattern-generator sweep controller.
// Register addresses follow the generator's 8-bit register write map.
package patgen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_LATCH,
        ST_RUN,
        ST_NEXT,
        ST_END
    } sweep_state_t;

    localparam logic [3:0] ADDR_NUMPULSES = 4'd7;
    localparam logic [3:0] ADDR_PERIODE   = 4'd8;
    localparam logic [3:0] ADDR_RUNLEN_H  = 4'd10;
    localparam logic [3:0] ADDR_RUNLEN_L  = 4'd11;
    localparam logic [3:0] ADDR_IDELAY_H  = 4'd12;
    localparam logic [3:0] ADDR_IDELAY_L  = 4'd13;
    localparam logic [3:0] ADDR_CLKFAC_H  = 4'd14;
    localparam logic [3:0] ADDR_CLKFAC_L  = 4'd15;

    localparam int WRITE_SEQ_LEN = 8;
    localparam int LATCH_CYCLES  = 2;

    // Unsigned add that clamps at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/patgen_sweep_ctrl_if.sv
// Connection between the sweep controller (master) and one pattern generator (slave).
interface patgen_sweep_ctrl_if;

    logic       pg_rfg_write;
    logic [3:0] pg_rfg_write_address;
    logic [7:0] pg_rfg_write_data;
    logic       pg_resn;
    logic       pg_suspend;
    logic       pg_running;
    logic       pg_done;

    modport master (
        output pg_rfg_write,
        output pg_rfg_write_address,
        output pg_rfg_write_data,
        output pg_resn,
        output pg_suspend,
        input  pg_running,
        input  pg_done
    );

    modport slave (
        input  pg_rfg_write,
        input  pg_rfg_write_address,
        input  pg_rfg_write_data,
        input  pg_resn,
        input  pg_suspend,
        output pg_running,
        output pg_done
    );

endinterface

// File: rtl/patgen_cfg_serializer.sv
// Streams the eight generator configuration bytes, one per clock, after a load pulse.
// Address and data read as zero whenever no write is in progress.
module patgen_cfg_serializer
    import patgen_pkg::*;
(
    input  logic        clk,
    input  logic        resn,
    input  logic        load,
    input  logic        clear,
    input  logic [7:0]  numpulses,
    input  logic [7:0]  periode,
    input  logic [15:0] runlen,
    input  logic [15:0] idelay,
    input  logic [15:0] clkfac,
    output logic        write,
    output logic [3:0]  address,
    output logic [7:0]  data,
    output logic        last
);

    logic       active;
    logic [2:0] idx;

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            active <= 1'b0;
            idx    <= '0;
        end else if (clear) begin
            active <= 1'b0;
            idx    <= '0;
        end else if (load) begin
            active <= 1'b1;
            idx    <= '0;
        end else if (active) begin
            idx <= idx + 3'd1;
            if (last) begin
                active <= 1'b0;
            end
        end
    end

    always_comb begin
        address = '0;
        data    = '0;
        if (active) begin
            unique case (idx)
                3'd0: begin address = ADDR_NUMPULSES; data = numpulses;     end
                3'd1: begin address = ADDR_PERIODE;   data = periode;       end
                3'd2: begin address = ADDR_RUNLEN_H;  data = runlen[15:8];  end
                3'd3: begin address = ADDR_RUNLEN_L;  data = runlen[7:0];   end
                3'd4: begin address = ADDR_IDELAY_H;  data = idelay[15:8];  end
                3'd5: begin address = ADDR_IDELAY_L;  data = idelay[7:0];   end
                3'd6: begin address = ADDR_CLKFAC_H;  data = clkfac[15:8];  end
                3'd7: begin address = ADDR_CLKFAC_L;  data = clkfac[7:0];   end
            endcase
        end
    end

    assign write = active;
    assign last  = active && (idx == 3'(WRITE_SEQ_LEN - 1));

endmodule

// File: rtl/patgen_sweep_ctrl.sv
// Automated injection sweep: programs the generator, runs it to done, and repeats
// with a growing initial delay, guarded by a per-step watchdog.
module patgen_sweep_ctrl
    import patgen_pkg::*;
#(
    parameter int TIMEOUT_W = 32,
    parameter int STEP_W    = 8
) (
    input  logic                 clk,
    input  logic                 resn,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 suspend_in,
    input  logic [7:0]           cfg_numpulses,
    input  logic [7:0]           cfg_periode,
    input  logic [15:0]          cfg_runlen,
    input  logic [15:0]          cfg_idelay_base,
    input  logic [15:0]          cfg_idelay_inc,
    input  logic [15:0]          cfg_clkfac,
    input  logic [STEP_W-1:0]    cfg_steps,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    patgen_sweep_ctrl_if.master  pg,
    output logic                 busy,
    output logic [STEP_W-1:0]    step_idx,
    output logic                 sweep_done,
    output logic                 err_cfg,
    output logic                 err_timeout
);

    sweep_state_t state, state_next;

    logic [7:0]           np_q;
    logic [7:0]           per_q;
    logic [15:0]          rl_q;
    logic [15:0]          inc_q;
    logic [15:0]          cf_q;
    logic [STEP_W-1:0]    steps_q;
    logic [TIMEOUT_W-1:0] tmo_q;
    logic [15:0]          cur_idelay;
    logic [1:0]           latch_cnt;
    logic [TIMEOUT_W-1:0] wdog;
    logic [TIMEOUT_W-1:0] wdog_inc;
    logic                 suspend_q;

    logic start_req, cfg_bad, accept, last_step, timeout_hit, latch_done, abort_hit;
    logic ser_load, ser_write, ser_last;
    logic [3:0] ser_addr;
    logic [7:0] ser_data;
    logic unused_running;

    assign unused_running = pg.pg_running;

    assign abort_hit   = abort && (state != ST_IDLE);
    assign start_req   = (state == ST_IDLE) && start && !abort;
    assign cfg_bad     = (cfg_runlen == '0) || (cfg_steps == '0);
    assign accept      = start_req && !cfg_bad;
    assign last_step   = (step_idx == steps_q - STEP_W'(1));
    assign latch_done  = (latch_cnt == 2'(LATCH_CYCLES - 1));
    assign wdog_inc    = wdog + TIMEOUT_W'(1);
    // The cycle being counted right now is included, so expiry lands exactly on cfg_timeout.
    assign timeout_hit = (tmo_q != '0) && !suspend_q && (wdog_inc == tmo_q);

    patgen_cfg_serializer u_serializer (
        .clk       (clk),
        .resn      (resn),
        .load      (ser_load),
        .clear     (abort_hit),
        .numpulses (np_q),
        .periode   (per_q),
        .runlen    (rl_q),
        .idelay    (cur_idelay),
        .clkfac    (cf_q),
        .write     (ser_write),
        .address   (ser_addr),
        .data      (ser_data),
        .last      (ser_last)
    );

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ser_load   = 1'b0;
        if (abort_hit) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state_next = ST_WRITE;
                        ser_load   = 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (ser_last) state_next = ST_LATCH;
                end
                ST_LATCH: begin
                    if (latch_done) state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (pg.pg_done) state_next = ST_NEXT;
                    else if (timeout_hit) state_next = ST_END;
                end
                ST_NEXT: begin
                    if (last_step) begin
                        state_next = ST_END;
                    end else begin
                        state_next = ST_WRITE;
                        ser_load   = 1'b1;
                    end
                end
                ST_END:  state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Snapshot, step bookkeeping, watchdog and sticky status flags.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            np_q        <= '0;
            per_q       <= '0;
            rl_q        <= '0;
            inc_q       <= '0;
            cf_q        <= '0;
            steps_q     <= '0;
            tmo_q       <= '0;
            cur_idelay  <= '0;
            latch_cnt   <= '0;
            wdog        <= '0;
            suspend_q   <= 1'b0;
            step_idx    <= '0;
            sweep_done  <= 1'b0;
            err_cfg     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            suspend_q <= suspend_in;
            latch_cnt <= (state == ST_LATCH) ? latch_cnt + 2'd1 : 2'd0;

            if (state == ST_RUN) begin
                if (!suspend_q) wdog <= wdog_inc;
            end else begin
                wdog <= '0;
            end

            if (start_req) begin
                sweep_done  <= 1'b0;
                err_timeout <= 1'b0;
                if (cfg_bad) begin
                    err_cfg <= 1'b1;
                end else begin
                    err_cfg    <= 1'b0;
                    np_q       <= cfg_numpulses;
                    per_q      <= cfg_periode;
                    rl_q       <= cfg_runlen;
                    inc_q      <= cfg_idelay_inc;
                    cf_q       <= cfg_clkfac;
                    steps_q    <= cfg_steps;
                    tmo_q      <= cfg_timeout;
                    cur_idelay <= cfg_idelay_base;
                    step_idx   <= '0;
                end
            end

            if (!abort_hit && (state == ST_RUN) && !pg.pg_done && timeout_hit) begin
                err_timeout <= 1'b1;
            end

            if (!abort_hit && (state == ST_NEXT)) begin
                if (last_step) begin
                    sweep_done <= 1'b1;
                end else begin
                    step_idx   <= step_idx + STEP_W'(1);
                    cur_idelay <= sat_add16(cur_idelay, inc_q);
                end
            end
        end
    end

    always_comb begin
        pg.pg_rfg_write         = (state == ST_WRITE) && ser_write;
        pg.pg_rfg_write_address = pg.pg_rfg_write ? ser_addr : 4'd0;
        pg.pg_rfg_write_data    = pg.pg_rfg_write ? ser_data : 8'd0;
        pg.pg_resn              = (state == ST_RUN);
        pg.pg_suspend           = suspend_q;
        busy                    = state inside {ST_WRITE, ST_LATCH, ST_RUN, ST_NEXT};
    end

endmodule

// File: tb/tb_patgen_sweep_ctrl.sv
// Self-checking bench for patgen_sweep_ctrl: directed sweeps plus randomized sweeps
// against an arithmetic model of the expected register bursts and timing.
`timescale 1ns/1ps
module tb_patgen_sweep_ctrl;

    localparam int TIMEOUT_W = 32;
    localparam int STEP_W    = 8;

    logic clk = 1'b0;
    logic resn = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic suspend_in = 1'b0;
    logic [7:0]           cfg_numpulses = '0;
    logic [7:0]           cfg_periode = '0;
    logic [15:0]          cfg_runlen = '0;
    logic [15:0]          cfg_idelay_base = '0;
    logic [15:0]          cfg_idelay_inc = '0;
    logic [15:0]          cfg_clkfac = '0;
    logic [STEP_W-1:0]    cfg_steps = '0;
    logic [TIMEOUT_W-1:0] cfg_timeout = '0;
    logic                 busy, sweep_done, err_cfg, err_timeout;
    logic [STEP_W-1:0]    step_idx;

    patgen_sweep_ctrl_if pg_bus ();
    assign pg_bus.pg_running = pg_bus.pg_resn;

    patgen_sweep_ctrl #(.TIMEOUT_W(TIMEOUT_W), .STEP_W(STEP_W)) dut (
        .clk             (clk),
        .resn            (resn),
        .start           (start),
        .abort           (abort),
        .suspend_in      (suspend_in),
        .cfg_numpulses   (cfg_numpulses),
        .cfg_periode     (cfg_periode),
        .cfg_runlen      (cfg_runlen),
        .cfg_idelay_base (cfg_idelay_base),
        .cfg_idelay_inc  (cfg_idelay_inc),
        .cfg_clkfac      (cfg_clkfac),
        .cfg_steps       (cfg_steps),
        .cfg_timeout     (cfg_timeout),
        .pg              (pg_bus),
        .busy            (busy),
        .step_idx        (step_idx),
        .sweep_done      (sweep_done),
        .err_cfg         (err_cfg),
        .err_timeout     (err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model of the sweep as the host configured it at start.
    logic [7:0]  m_np, m_per;
    logic [15:0] m_rl, m_base, m_inc, m_cf;
    int          m_steps;

    logic [3:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         wr_cyc_q[$];
    logic       susp_model;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic logic [31:0] packOutputs();
        return {5'd0, pg_bus.pg_rfg_write, pg_bus.pg_rfg_write_address, pg_bus.pg_rfg_write_data,
                pg_bus.pg_resn, pg_bus.pg_suspend, busy, step_idx, sweep_done, err_cfg, err_timeout};
    endfunction

    function automatic logic [15:0] expIdelay(input int k);
        int unsigned v;
        v = int'(m_base) + k * int'(m_inc);
        return (v > 32'd65535) ? 16'hFFFF : v[15:0];
    endfunction

    function automatic logic [11:0] expWrite(input int k, input int i);
        logic [15:0] id;
        id = expIdelay(k);
        case (i)
            0:       return {4'd7,  m_np};
            1:       return {4'd8,  m_per};
            2:       return {4'd10, m_rl[15:8]};
            3:       return {4'd11, m_rl[7:0]};
            4:       return {4'd12, id[15:8]};
            5:       return {4'd13, id[7:0]};
            6:       return {4'd14, m_cf[15:8]};
            default: return {4'd15, m_cf[7:0]};
        endcase
    endfunction

    always @(posedge clk or negedge resn) begin
        if (!resn) susp_model <= 1'b0;
        else       susp_model <= suspend_in;
    end

    always @(negedge clk) begin
        if (pg_bus.pg_rfg_write) begin
            wr_addr_q.push_back(pg_bus.pg_rfg_write_address);
            wr_data_q.push_back(pg_bus.pg_rfg_write_data);
            wr_cyc_q.push_back(cyc);
        end
        if (resn) checkOutput("suspend_fwd", {31'd0, pg_bus.pg_suspend}, {31'd0, susp_model});
    end

    task automatic applyStimulus(input logic [7:0] np, input logic [7:0] per, input logic [15:0] rl,
                                 input logic [15:0] base, input logic [15:0] inc, input logic [15:0] cf,
                                 input logic [7:0] steps, input logic [31:0] tmo);
        cfg_numpulses = np;   cfg_periode = per;   cfg_runlen = rl;
        cfg_idelay_base = base; cfg_idelay_inc = inc; cfg_clkfac = cf;
        cfg_steps = steps;    cfg_timeout = tmo;
        m_np = np; m_per = per; m_rl = rl; m_base = base; m_inc = inc; m_cf = cf; m_steps = int'(steps);
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic scrambleCfg();
        cfg_numpulses = 8'($urandom);  cfg_periode = 8'($urandom);
        cfg_runlen = 16'($urandom);    cfg_idelay_base = 16'($urandom);
        cfg_idelay_inc = 16'($urandom); cfg_clkfac = 16'($urandom);
        cfg_steps = 8'($urandom);
    endtask

    task automatic waitRunEntry(output bit found);
        found = 1'b0;
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            if (pg_bus.pg_resn) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("run_entry", {31'd0, found}, 32'd1);
    endtask

    task automatic runSweep(input bit scramble);
        int run_cyc, done_cyc, d, base_i;
        bit found;
        logic [11:0] ew;
        done_cyc = 0;
        for (int k = 0; k < m_steps; k++) begin
            if (scramble && k == 0) scrambleCfg();
            waitRunEntry(found);
            if (!found) return;
            run_cyc = cyc;
            base_i = 8 * k;
            checkOutput("burst_len", wr_addr_q.size(), 8 * (k + 1));
            if (wr_addr_q.size() < 8 * (k + 1)) return;
            for (int i = 0; i < 8; i++) begin
                ew = expWrite(k, i);
                checkOutput($sformatf("wr_addr s%0d i%0d", k, i), {28'd0, wr_addr_q[base_i + i]}, {28'd0, ew[11:8]});
                checkOutput($sformatf("wr_data s%0d i%0d", k, i), {24'd0, wr_data_q[base_i + i]}, {24'd0, ew[7:0]});
                if (i > 0) checkOutput("wr_back2back", wr_cyc_q[base_i + i], wr_cyc_q[base_i] + i);
            end
            checkOutput("latch_gap", run_cyc - wr_cyc_q[base_i + 7], 3);
            checkOutput("first_wr_cycle", wr_cyc_q[base_i], (k == 0) ? start_cyc + 1 : done_cyc + 2);
            checkOutput("step_idx_run", {24'd0, step_idx}, k);
            checkOutput("busy_run", {31'd0, busy}, 32'd1);
            if (scramble) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            d = $urandom_range(0, 4);
            repeat (d) @(negedge clk);
            checkOutput("resn_in_run", {31'd0, pg_bus.pg_resn}, 32'd1);
            pg_bus.pg_done = 1'b1;
            done_cyc = cyc;
            @(negedge clk);
            pg_bus.pg_done = 1'b0;
            checkOutput("resn_next", {31'd0, pg_bus.pg_resn}, 32'd0);
            checkOutput("busy_next", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        checkOutput("busy_end", {31'd0, busy}, 32'd0);
        checkOutput("sweep_done_end", {31'd0, sweep_done}, 32'd1);
        checkOutput("step_idx_end", {24'd0, step_idx}, m_steps - 1);
        checkOutput("flags_end", {30'd0, err_cfg, err_timeout}, 32'd0);
        checkOutput("burst_total", wr_addr_q.size(), 8 * m_steps);
    endtask

    task automatic timeoutTest(input int susp_cycles);
        int r;
        bit found, seen;
        applyStimulus(8'd3, 8'd2, 16'd5, 16'd10, 16'd1, 16'd0, 8'd1, 32'd50);
        waitRunEntry(found);
        if (!found) return;
        r = cyc;
        if (susp_cycles > 0) suspend_in = 1'b1;
        seen = 1'b0;
        for (int w = 1; w <= 300; w++) begin
            @(negedge clk);
            if (w == susp_cycles) suspend_in = 1'b0;
            if (err_timeout) begin
                seen = 1'b1;
                checkOutput("timeout_cycle", cyc - r, 50 + susp_cycles);
                checkOutput("timeout_resn", {31'd0, pg_bus.pg_resn}, 32'd0);
                checkOutput("timeout_busy", {31'd0, busy}, 32'd0);
                checkOutput("timeout_no_done", {31'd0, sweep_done}, 32'd0);
                break;
            end
        end
        suspend_in = 1'b0;
        checkOutput("timeout_seen", {31'd0, seen}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit found;
        pg_bus.pg_done = 1'b0;
        suspend_in = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", packOutputs(), 32'd0);
        suspend_in = 1'b0;
        resn = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_after_reset", packOutputs(), 32'd0);

        $display("[TB] basic sweep");
        applyStimulus(8'd0, 8'd1, 16'd1, 16'd4, 16'd2, 16'd0, 8'd3, 32'd0);
        runSweep(1'b0);

        $display("[TB] illegal configurations");
        applyStimulus(8'd1, 8'd1, 16'd0, 16'd4, 16'd2, 16'd0, 8'd5, 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("illegal_rl_flags", {29'd0, err_cfg, sweep_done, busy}, 32'h4);
        checkOutput("illegal_rl_writes", wr_addr_q.size(), 0);
        applyStimulus(8'd1, 8'd1, 16'd7, 16'd4, 16'd2, 16'd0, 8'd0, 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("illegal_steps_flags", {29'd0, err_cfg, sweep_done, busy}, 32'h4);
        checkOutput("illegal_steps_writes", wr_addr_q.size(), 0);

        $display("[TB] saturating idelay");
        applyStimulus(8'h12, 8'h34, 16'h0102, 16'hFFF0, 16'h0010, 16'hA5C3, 8'd3, 32'd0);
        runSweep(1'b0);

        $display("[TB] randomized sweeps");
        for (int t = 0; t < 6; t++) begin
            suspend_in = 1'($urandom_range(0, 1));
            applyStimulus(8'($urandom), 8'($urandom), 16'($urandom_range(1, 65535)),
                          ($urandom_range(0, 1) != 0) ? 16'($urandom_range(65000, 65535)) : 16'($urandom),
                          16'($urandom), 16'($urandom), 8'($urandom_range(1, 4)),
                          ($urandom_range(0, 1) != 0) ? 32'd0 : 32'd1000);
            runSweep(1'b1);
            suspend_in = 1'b0;
        end

        $display("[TB] watchdog");
        timeoutTest(0);
        timeoutTest(20);

        $display("[TB] abort during burst");
        applyStimulus(8'd9, 8'd9, 16'd9, 16'd9, 16'd9, 16'd9, 8'd2, 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_outputs", {28'd0, pg_bus.pg_rfg_write, pg_bus.pg_resn, busy, step_idx == 8'd0}, 32'h1);
        checkOutput("abort_flags", {29'd0, sweep_done, err_cfg, err_timeout}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("abort_write_count", wr_addr_q.size(), 4);

        $display("[TB] sweep after abort");
        applyStimulus(8'h55, 8'hAA, 16'h1234, 16'h0100, 16'h0001, 16'h0F0F, 8'd2, 32'd0);
        runSweep(1'b0);

        $display("[TB] async reset during run");
        applyStimulus(8'd1, 8'd2, 16'd3, 16'd4, 16'd5, 16'd6, 8'd2, 32'd0);
        waitRunEntry(found);
        #2;
        resn = 1'b0;
        #1;
        checkOutput("async_reset", packOutputs(), 32'd0);
        repeat (2) @(negedge clk);
        resn = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_reset_idle", packOutputs(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "[TB] bench did not finish");
    end

endmodule

// File: doc/patgen_sweep_ctrl.md
Name: patgen_sweep_ctrl

Overview:
Sequencer that drives one sync_async_patgen instance through an automated injection sweep. It serialises configuration bytes into the pattern generator's 8-bit register write port and holds the generator in reset while they are latched. It then releases the generator, waits for done, and repeats for N steps, adding a programmable increment to the initial delay at each step. It sits between the host register file and the pattern generator, replacing manual host-driven programming.

Parameters:
TIMEOUT_W, 32, width of the per-step watchdog counter and of cfg_timeout.
STEP_W, 8, width of the sweep step count and step index.

Ports:
clk  in  1  system clock
resn  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins sweep when idle
abort  in  1  single-cycle pulse; cancels sweep from any state
suspend_in  in  1  host pause request, forwarded to generator
cfg_numpulses  in  8  pulses per set (raw byte, written to addr 7)
cfg_periode  in  8  pulse length byte (addr 8)
cfg_runlen  in  16  pulse sets per step (addrs 10/11); 0 is illegal
cfg_idelay_base  in  16  initial delay for step 0
cfg_idelay_inc  in  16  idelay increment per step
cfg_clkfac  in  16  clock divider (addrs 14/15)
cfg_steps  in  STEP_W  number of sweep steps; 0 is illegal
cfg_timeout  in  TIMEOUT_W  clk cycles allowed per step; 0 disables the watchdog
pg_rfg_write  out  1  generator register write strobe
pg_rfg_write_address  out  4  generator register address
pg_rfg_write_data  out  8  generator register data
pg_resn  out  1  generator reset (active low)
pg_suspend  out  1  generator suspend
pg_running  in  1  generator running flag
pg_done  in  1  generator done flag
busy  out  1  sweep in progress
step_idx  out  STEP_W  index of the current or last step
sweep_done  out  1  sticky; set on normal completion
err_cfg  out  1  sticky; illegal config at start
err_timeout  out  1  sticky; watchdog expired

Behaviour:
- Reset values: pg_rfg_write=0, address=0, data=0, pg_resn=0, pg_suspend=0, busy=0, step_idx=0, sweep_done=0, err_cfg=0, err_timeout=0; state IDLE.
- pg_suspend = suspend_in, registered, 1-cycle latency, in all states.
- The block has six states: IDLE, WRITE, LATCH, RUN, NEXT, END.
- IDLE: pg_resn=0.
  - On start with cfg_runlen==0 or cfg_steps==0: set err_cfg, clear the other sticky flags, stay in IDLE.
  - Otherwise: snapshot all cfg_* into internal registers, clear sticky flags, step_idx=0, cur_idelay=cfg_idelay_base, busy=1, go to WRITE.
- WRITE: pg_resn=0. Issue 8 consecutive single-cycle writes with pg_rfg_write=1, one per clk, in this address order:
  - 7 numpulses
  - 8 periode
  - 10 runlen[15:8]
  - 11 runlen[7:0]
  - 12 cur_idelay[15:8]
  - 13 cur_idelay[7:0]
  - 14 clkfac[15:8]
  - 15 clkfac[7:0]
  - After the 8th write go to LATCH.
- LATCH: pg_rfg_write=0, pg_resn=0 for exactly 2 cycles, so the generator's reset branch samples the final register values. Clear the watchdog counter. Go to RUN.
- RUN: pg_resn=1.
  - Watchdog increments each cycle while pg_suspend=0.
  - pg_done=1: go to NEXT.
  - Otherwise, if cfg_timeout!=0 and the counter reaches cfg_timeout: set err_timeout, go to END.
  - pg_done takes priority over timeout in the same cycle.
- NEXT (1 cycle): pg_resn=0.
  - If step_idx==steps-1: set sweep_done, go to END.
  - Otherwise: step_idx+1; cur_idelay = cur_idelay + inc, saturating at 16'hFFFF; go to WRITE.
- END (1 cycle): pg_resn=0, busy=0, go to IDLE.
- abort: in any non-IDLE state, the next cycle is pg_rfg_write=0, pg_resn=0, busy=0, state IDLE. No sticky flag is set; step_idx is held. Abort takes priority over all other transitions.
- start while busy is ignored. start and abort in the same cycle in IDLE: abort wins and start is ignored.
- cfg_* changes during a sweep have no effect (snapshot only).
- pg_running is status only and does not affect transitions.

Decomposition:
- Package patgen_pkg:
  - state enum
  - generator register address constants (ADDR_NUMPULSES=7, ADDR_PERIODE=8, ADDR_RUNLEN_H=10 … ADDR_CLKFAC_L=15)
  - WRITE_SEQ_LEN=8
  - LATCH_CYCLES=2
- One natural sub-module, patgen_cfg_serializer: an 8-entry address/data mux plus write counter, with a load pulse in and a last flag out.
- Watchdog and step logic stay in the top module.

Test Plan:
- Basic sweep: runlen=1, numpulses=0, periode=1, clkfac=0, base=4, inc=2, steps=3 -> three WRITE bursts; addr 12/13 bytes are 0x00/0x04, 0x00/0x06, 0x00/0x08; sweep_done=1 after the 3rd pg_done; busy falls 1 cycle after NEXT.
- Write timing: start -> pg_rfg_write high for 8 consecutive cycles with addresses 7,8,10,11,12,13,14,15; pg_resn low through both LATCH cycles; pg_resn rises on RUN entry.
- Illegal config: runlen=0, steps=5, start -> err_cfg=1, busy stays 0, no pg_rfg_write pulses.
- Timeout: cfg_timeout=50, generator model never asserts done -> err_timeout=1 exactly 50 unsuspended RUN cycles after RUN entry; pg_resn=0; busy=0. Repeat with suspend_in held for 20 cycles -> expiry delayed by 20.
- Saturation: base=0xFFF0, inc=0x0010, steps=3 -> step idelay values 0xFFF0, 0xFFFF, 0xFFFF.
- Abort and reset: abort during the 4th WRITE cycle -> next cycle pg_rfg_write=0, busy=0, state IDLE, no flags set. Async resn low mid-RUN -> all outputs at reset values immediately, without waiting for a clk edge.
